// File: rtl/scmi_doorbell_irq_ctrl.sv
// Doorbell interrupt controller: edge-detects mailbox doorbell levels into pending flags and
// saturating counters, raises a masked irq, and serves round-robin claims over valid/ready.
module scmi_doorbell_irq_ctrl #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 4,
  localparam int unsigned ID_W  = $clog2(NUM_CH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_CH-1:0] doorbell_i,
  input  logic [NUM_CH-1:0] mask_i,
  output logic              irq_o,
  input  logic              claim_valid_i,
  output logic              claim_ready_o,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [ID_W-1:0]   resp_id_o,
  output logic [CNT_W-1:0]  resp_cnt_o,
  output logic              resp_ovf_o
);

  typedef enum logic [0:0] {StIdle, StResp} state_e;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  state_e                         state_q, state_d;
  logic [NUM_CH-1:0]              prev_q;
  logic [NUM_CH-1:0]              pending_q, pending_d;
  logic [NUM_CH-1:0]              ovf_q, ovf_d;
  logic [NUM_CH-1:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]                rr_q, rr_d;
  logic                           irq_q;
  logic [ID_W-1:0]                resp_id_q, resp_id_d;
  logic [CNT_W-1:0]               resp_cnt_q, resp_cnt_d;
  logic                           resp_ovf_q, resp_ovf_d;

  logic [NUM_CH-1:0] db_edge;
  logic [NUM_CH-1:0] eligible;
  logic [ID_W-1:0]   sel;
  logic              found;
  logic              claim_fire;
  int unsigned       idx;

  assign db_edge  = doorbell_i & ~prev_q;
  assign eligible = pending_q & mask_i;

  // Round-robin scan starting at rr_q, wrapping modulo NUM_CH.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        sel   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    claim_ready_o = 1'b0;
    resp_valid_o  = 1'b0;
    unique case (state_q)
      StIdle: begin
        claim_ready_o = |eligible;
        if (claim_valid_i && claim_ready_o) state_d = StResp;
      end
      StResp: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign claim_fire = claim_valid_i & claim_ready_o;

  always_comb begin
    pending_d  = pending_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    rr_d       = rr_q;
    resp_id_d  = resp_id_q;
    resp_cnt_d = resp_cnt_q;
    resp_ovf_d = resp_ovf_q;
    if (claim_fire) begin
      resp_id_d  = sel;
      resp_cnt_d = cnt_q[sel];
      resp_ovf_d = ovf_q[sel];
      rr_d       = (int'(sel) == NUM_CH - 1) ? '0 : sel + ID_W'(1);
    end
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (claim_fire && (int'(sel) == i)) begin
        // A same-cycle edge survives the claim as a fresh single event.
        pending_d[i] = db_edge[i];
        cnt_d[i]     = db_edge[i] ? CNT_W'(1) : '0;
        ovf_d[i]     = 1'b0;
      end else if (db_edge[i]) begin
        pending_d[i] = 1'b1;
        if (cnt_q[i] == CntMax) ovf_d[i] = 1'b1;
        else                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      prev_q     <= '0;
      pending_q  <= '0;
      cnt_q      <= '0;
      ovf_q      <= '0;
      rr_q       <= '0;
      irq_q      <= 1'b0;
      resp_id_q  <= '0;
      resp_cnt_q <= '0;
      resp_ovf_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= doorbell_i;
      pending_q  <= pending_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      rr_q       <= rr_d;
      irq_q      <= |eligible;
      resp_id_q  <= resp_id_d;
      resp_cnt_q <= resp_cnt_d;
      resp_ovf_q <= resp_ovf_d;
    end
  end

  assign irq_o      = irq_q;
  assign resp_id_o  = resp_id_q;
  assign resp_cnt_o = resp_cnt_q;
  assign resp_ovf_o = resp_ovf_q;

endmodule

// File: tb/tb_scmi_doorbell_irq_ctrl.sv
// Directed bench for scmi_doorbell_irq_ctrl with 4 channels and 4-bit counters.
module tb_scmi_doorbell_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] doorbell;
  logic [3:0] mask;
  logic       irq;
  logic       claim_valid;
  logic       claim_ready;
  logic       resp_valid;
  logic       resp_ready;
  logic [1:0] resp_id;
  logic [3:0] resp_cnt;
  logic       resp_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  scmi_doorbell_irq_ctrl #(
    .NUM_CH(4),
    .CNT_W (4)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .doorbell_i   (doorbell),
    .mask_i       (mask),
    .irq_o        (irq),
    .claim_valid_i(claim_valid),
    .claim_ready_o(claim_ready),
    .resp_valid_o (resp_valid),
    .resp_ready_i (resp_ready),
    .resp_id_o    (resp_id),
    .resp_cnt_o   (resp_cnt),
    .resp_ovf_o   (resp_ovf)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; doorbell = '0; mask = '0; claim_valid = 1'b0; resp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] bits);
    doorbell = bits;
    tick();
    doorbell = '0;
    tick();
  endtask

  task automatic accept();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", irq); end
    n_checks++;
    if (claim_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_claim_ready got %b want 0", claim_ready);
    end
    n_checks++;
    if (resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_resp_valid got %b want 0", resp_valid);
    end
    n_checks++;
    if ({resp_id, resp_cnt, resp_ovf} !== 7'd0) begin
      n_fail++; $display("FAIL reset_resp_regs got %h want 0", {resp_id, resp_cnt, resp_ovf});
    end
  endtask

  task automatic test_count();
    do_reset();
    mask = 4'b1111;
    doorbell = 4'b0100;
    tick();
    doorbell = '0;
    tick();
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL count_irq_rise got %b want 1", irq); end
    pulse(4'b0100);
    pulse(4'b0100);
    claim_valid = 1'b1;
    n_checks++;
    if (claim_ready !== 1'b1) begin
      n_fail++; $display("FAIL count_claim_ready got %b want 1", claim_ready);
    end
    tick();
    claim_valid = 1'b0;
    n_checks++;
    if ({resp_valid, resp_id, resp_cnt, resp_ovf} !== {1'b1, 2'd2, 4'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL count_resp got v=%b id=%0d cnt=%0d ovf=%b want v=1 id=2 cnt=3 ovf=0",
               resp_valid, resp_id, resp_cnt, resp_ovf);
    end
    accept();
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL count_irq_fall got %b want 0", irq); end
    n_checks++;
    if (resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL count_resp_drop got %b want 0", resp_valid);
    end
  endtask

  task automatic test_level_hold();
    do_reset();
    mask = 4'b1111;
    doorbell = 4'b0010;
    for (int i = 0; i < 10; i++) tick();
    doorbell = '0;
    tick();
    claim_valid = 1'b1;
    tick();
    claim_valid = 1'b0;
    n_checks++;
    if ({resp_id, resp_cnt} !== {2'd1, 4'd1}) begin
      n_fail++; $display("FAIL level_hold got id=%0d cnt=%0d want id=1 cnt=1", resp_id, resp_cnt);
    end
    accept();
  endtask

  task automatic test_overflow();
    do_reset();
    mask = 4'b1111;
    for (int i = 0; i < 17; i++) pulse(4'b0001);
    claim_valid = 1'b1;
    tick();
    claim_valid = 1'b0;
    n_checks++;
    if ({resp_id, resp_cnt, resp_ovf} !== {2'd0, 4'd15, 1'b1}) begin
      n_fail++;
      $display("FAIL overflow_resp got id=%0d cnt=%0d ovf=%b want id=0 cnt=15 ovf=1",
               resp_id, resp_cnt, resp_ovf);
    end
    accept();
    claim_valid = 1'b1;
    n_checks++;
    if (claim_ready !== 1'b0) begin
      n_fail++; $display("FAIL overflow_second_claim got %b want 0", claim_ready);
    end
    tick();
    claim_valid = 1'b0;
    n_checks++;
    if (resp_valid !== 1'b0) begin
      n_fail++; $display("FAIL overflow_no_resp got %b want 0", resp_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_ids [3];
    exp_ids[0] = 2'd0; exp_ids[1] = 2'd1; exp_ids[2] = 2'd3;
    do_reset();
    mask = 4'b1011;
    pulse(4'b1111);
    for (int k = 0; k < 3; k++) begin
      claim_valid = 1'b1;
      n_checks++;
      if (claim_ready !== 1'b1) begin
        n_fail++; $display("FAIL rr_ready_%0d got %b want 1", k, claim_ready);
      end
      tick();
      claim_valid = 1'b0;
      n_checks++;
      if (resp_id !== exp_ids[k]) begin
        n_fail++; $display("FAIL rr_id_%0d got %0d want %0d", k, resp_id, exp_ids[k]);
      end
      accept();
    end
    claim_valid = 1'b1;
    n_checks++;
    if (claim_ready !== 1'b0) begin
      n_fail++; $display("FAIL rr_fourth_stall got %b want 0", claim_ready);
    end
    tick();
    claim_valid = 1'b0;
    // Channel 2 is still pending behind its mask; unmask, then mask it again.
    mask = 4'b0100;
    tick();
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL rr_unmask_irq got %b want 1", irq); end
    mask = 4'b0000;
    tick();
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL rr_mask_irq_fall got %b want 0", irq); end
  endtask

  task automatic test_collision();
    do_reset();
    mask = 4'b1111;
    pulse(4'b0001);
    pulse(4'b0001);
    doorbell = 4'b0001;
    claim_valid = 1'b1;
    tick();
    claim_valid = 1'b0;
    n_checks++;
    if ({resp_valid, resp_id, resp_cnt, resp_ovf} !== {1'b1, 2'd0, 4'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL collide_resp got v=%b id=%0d cnt=%0d ovf=%b want v=1 id=0 cnt=2 ovf=0",
               resp_valid, resp_id, resp_cnt, resp_ovf);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if ({resp_valid, resp_id, resp_cnt, resp_ovf} !== {1'b1, 2'd0, 4'd2, 1'b0}) begin
        n_fail++;
        $display("FAIL collide_hold_%0d got v=%b id=%0d cnt=%0d ovf=%b want v=1 id=0 cnt=2 ovf=0",
                 i, resp_valid, resp_id, resp_cnt, resp_ovf);
      end
    end
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL collide_irq_kept got %b want 1", irq); end
    accept();
    claim_valid = 1'b1;
    tick();
    claim_valid = 1'b0;
    n_checks++;
    if ({resp_valid, resp_id, resp_cnt, resp_ovf} !== {1'b1, 2'd0, 4'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL collide_new_edge got v=%b id=%0d cnt=%0d ovf=%b want v=1 id=0 cnt=1 ovf=0",
               resp_valid, resp_id, resp_cnt, resp_ovf);
    end
    rst = 1'b1;
    doorbell = '0;
    tick();
    n_checks++;
    if ({resp_valid, irq} !== 2'b00) begin
      n_fail++; $display("FAIL collide_reset got valid=%b irq=%b want 0 0", resp_valid, irq);
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count();
    test_level_hold();
    test_overflow();
    test_round_robin();
    test_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
